// File: rtl/comp_share_pkg.sv
// Shared constants and response record for the comparator-sharing arbiter.
// No logic; types and widths only.
// No flow control; consumers apply their own.
package comp_share_pkg;
    localparam int DATA_W      = 28;
    localparam int DEF_NUM_REQ = 4;
    localparam int ID_W        = $clog2(DEF_NUM_REQ);

    typedef struct packed {
        logic            less;
        logic [ID_W-1:0] id;
    } rsp_t;
endpackage

// File: rtl/COMP_28bit.sv
// 28-bit unsigned magnitude comparator, o_less = a < b.
// Purely combinational, zero latency.
// No flow control.
module COMP_28bit (
    input  logic [27:0] i_a,
    input  logic [27:0] i_b,
    output logic        o_less
);
    assign o_less = (i_a < i_b);
endmodule

// File: rtl/comp_share_arbiter_rr_grant.sv
// Round-robin priority picker: first set request strictly after ptr, wrapping.
// Combinational, zero latency.
// No flow control; the caller gates the grant with its own ready.
module rr_grant #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx,
    output logic           any
);
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 1; i <= N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end
endmodule

// File: rtl/comp_share_arbiter.sv
// Shares one 28-bit comparator among NUM_REQ requesters with round-robin grant.
// Latency 1 cycle from accept to o_rsp_valid; one result per cycle back-to-back.
// Grants only when the single response slot is empty or draining this cycle.
module comp_share_arbiter #(
    parameter int NUM_REQ = comp_share_pkg::DEF_NUM_REQ,
    parameter int DATA_W  = comp_share_pkg::DATA_W,
    parameter int CNT_W   = 16,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  i_req_a,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  i_req_b,
    output logic [NUM_REQ-1:0]              o_req_ready,
    output logic                            o_rsp_valid,
    output logic                            o_rsp_less,
    output logic [IDW-1:0]                  o_rsp_id,
    input  logic                            i_rsp_ready,
    output logic [CNT_W-1:0]                o_cmp_cnt
);
    typedef struct packed {
        logic           less;
        logic [IDW-1:0] id;
    } slot_t;

    logic               slot_free;
    logic               accept;
    logic               any_vld;
    logic               cmp_less;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     ptr_q;
    logic [DATA_W-1:0]  cmp_a;
    logic [DATA_W-1:0]  cmp_b;
    slot_t              slot_q;
    logic               rsp_vld_q;
    logic [CNT_W-1:0]   cnt_q;

    rr_grant #(.N(NUM_REQ), .IDW(IDW)) u_rr (
        .req (i_req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (any_vld)
    );

    // A draining slot can be refilled in the same cycle.
    assign slot_free   = !rsp_vld_q || i_rsp_ready;
    assign o_req_ready = (slot_free && !i_rst) ? gnt : '0;
    assign accept      = any_vld && slot_free && !i_rst;

    assign cmp_a = i_req_a[gnt_idx];
    assign cmp_b = i_req_b[gnt_idx];

    COMP_28bit u_cmp (
        .i_a    (cmp_a),
        .i_b    (cmp_b),
        .o_less (cmp_less)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rsp_vld_q <= 1'b0;
            slot_q    <= '0;
            ptr_q     <= IDW'(NUM_REQ - 1);
        end else if (accept) begin
            rsp_vld_q <= 1'b1;
            slot_q    <= '{less: cmp_less, id: gnt_idx};
            ptr_q     <= gnt_idx;
        end else if (i_rsp_ready) begin
            rsp_vld_q <= 1'b0;
        end
    end

    // Debug count of consumed responses; sticks at all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (rsp_vld_q && i_rsp_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_rsp_valid = rsp_vld_q;
    assign o_rsp_less  = slot_q.less;
    assign o_rsp_id    = slot_q.id;
    assign o_cmp_cnt   = cnt_q;
endmodule
